obuft_drive_ctrl: RTL and testbench

OBUFT_DRIVE_CTRL -- requirements
Module: obuft_drive_ctrl

---
 rtl/obuft_drive_pkg.sv | 22 ++
 rtl/obuft_drive_shreg.sv | 50 +++++
 rtl/obuft_drive_ctrl.sv | 110 +++++++++++
 tb/tb_obuft_drive_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/obuft_drive_pkg.sv
// Shared types, defaults and helper for the OBUFT drive controller.
// Build with OBUFT_DRIVE_PARITY_EN defined to add an odd-parity bit after each word.
package obuft_drive_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_TURN  = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_TURN
`ifdef OBUFT_DRIVE_PARITY_EN
    , ST_PAR
`endif
  } state_e;

  // Zero-extension does not change the XOR, so one 32-bit version serves every WIDTH.
  function automatic logic odd_parity(input logic [31:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/obuft_drive_shreg.sv
// Load/shift register and remaining-bit down-counter for the serializer.
// The word's MSB goes straight to the output flop, so only the lower WIDTH-1 bits are held here.
module obuft_drive_shreg
  import obuft_drive_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-2:0] data_i,
  output logic             msb_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // The counter holds the bits still to come after the one on O_I; zero marks the last bit.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = CW'(WIDTH - 1);
    end else if (shift_i) begin
      shreg_d = shreg_q << 1;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign msb_o  = shreg_q[WIDTH-2];
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/obuft_drive_ctrl.sv
// Serializes parallel words onto the I/T pair of an external tri-state output buffer.
// Define OBUFT_DRIVE_PARITY_EN to append one odd-parity bit cycle after each word.
module obuft_drive_ctrl
  import obuft_drive_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int TURN  = DEFAULT_TURN
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             O_I,
  output logic             O_T,
  output logic             BUSY
);

  state_e     state_q;
  logic       oi_q;
  logic       ot_q;
  logic [3:0] turn_q;
  logic       bit_msb;
  logic       last_bit;
  logic       word_end;
  logic       handshake;
  logic       shift_en;
`ifdef OBUFT_DRIVE_PARITY_EN
  logic       parity_q;
`endif

`ifdef OBUFT_DRIVE_PARITY_EN
  assign word_end = (state_q == ST_PAR);
`else
  assign word_end = (state_q == ST_SHIFT) && last_bit;
`endif

  assign DIN_READY = !RST && ((state_q == ST_IDLE) || word_end);
  assign BUSY      = !RST && (state_q != ST_IDLE);
  assign handshake = DIN_READY && DIN_VALID;
  assign shift_en  = (state_q == ST_SHIFT) && !last_bit;

  obuft_drive_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (handshake),
    .shift_i(shift_en),
    .data_i (DIN[WIDTH-2:0]),
    .msb_o  (bit_msb),
    .last_o (last_bit)
  );

  // A handshake on the final cycle of a word reloads without leaving SHIFT, keeping O_T low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      oi_q    <= 1'b0;
      ot_q    <= 1'b1;
      turn_q  <= '0;
`ifdef OBUFT_DRIVE_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (handshake) begin
      state_q <= ST_SHIFT;
      oi_q    <= DIN[WIDTH-1];
      ot_q    <= 1'b0;
`ifdef OBUFT_DRIVE_PARITY_EN
      parity_q <= odd_parity(32'(DIN));
`endif
    end else if (word_end) begin
      oi_q <= 1'b0;
      ot_q <= 1'b1;
      if (TURN != 0) begin
        state_q <= ST_TURN;
        turn_q  <= 4'(TURN - 1);
      end else begin
        state_q <= ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_SHIFT: begin
`ifdef OBUFT_DRIVE_PARITY_EN
          if (last_bit) begin
            state_q <= ST_PAR;
            oi_q    <= parity_q;
          end else begin
            oi_q <= bit_msb;
          end
`else
          oi_q <= bit_msb;
`endif
        end
        ST_TURN: begin
          if (turn_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            turn_q <= turn_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign O_I = oi_q;
  assign O_T = ot_q;

endmodule

// File: tb/tb_obuft_drive_ctrl.sv
// Directed and model-checked bench for obuft_drive_ctrl (WIDTH=8, TURN=1 and TURN=0 instances).
// Observed outputs are compared as the packed vector {O_I, O_T, DIN_READY, BUSY}.
module tb_obuft_drive_ctrl;

`ifdef OBUFT_DRIVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 8 + PAR;

  logic       clk = 1'b0;
  logic       rst0, val0, rdy0, oi0, ot0, busy0;
  logic       rst1, val1, rdy1, oi1, ot1, busy1;
  logic [7:0] din0, din1;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  obuft_drive_ctrl #(.WIDTH(8), .TURN(1)) dut0 (
    .CLK(clk), .RST(rst0), .DIN(din0), .DIN_VALID(val0),
    .DIN_READY(rdy0), .O_I(oi0), .O_T(ot0), .BUSY(busy0)
  );

  obuft_drive_ctrl #(.WIDTH(8), .TURN(0)) dut1 (
    .CLK(clk), .RST(rst1), .DIN(din1), .DIN_VALID(val1),
    .DIN_READY(rdy1), .O_I(oi1), .O_T(ot1), .BUSY(busy1)
  );

  // Every sample and every input change happens 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst0 = 1'b1; rst1 = 1'b1; val0 = 1'b0; val1 = 1'b0; din0 = 8'h00; din1 = 8'h00;
    step(); step();
    obs = {oi0, ot0, rdy0, busy0};
    nCompared++;
    if (obs !== 4'b0100) begin
      nMismatched++;
      $display("[TB] FAIL reset_hold0 got %b want %b", obs, 4'b0100);
    end
    obs = {oi1, ot1, rdy1, busy1};
    nCompared++;
    if (obs !== 4'b0100) begin
      nMismatched++;
      $display("[TB] FAIL reset_hold1 got %b want %b", obs, 4'b0100);
    end
    rst0 = 1'b0; rst1 = 1'b0;
    step();
    obs = {oi0, ot0, rdy0, busy0};
    nCompared++;
    if (obs !== 4'b0110) begin
      nMismatched++;
      $display("[TB] FAIL reset_release got %b want %b", obs, 4'b0110);
    end
  endtask

  // 0xA5 on TURN=1: bits 1,0,1,0,0,1,0,1 then (parity 1) then one TURN cycle, then IDLE.
  task automatic test_single();
    logic [7:0] wd;
    logic [3:0] obs, expv;
    wd = 8'hA5;
    din0 = wd; val0 = 1'b1;
    step();
    val0 = 1'b0; din0 = 8'h3C;
    for (int i = 0; i < NB; i++) begin
      expv = {(i < 8) ? wd[7 - i] : 1'b1, 1'b0, (i == NB - 1), 1'b1};
      obs  = {oi0, ot0, rdy0, busy0};
      nCompared++;
      if (obs !== expv) begin
        nMismatched++;
        $display("[TB] FAIL single_bit%0d got %b want %b", i, obs, expv);
      end
      val0 = (i == 3);
      step();
    end
    val0 = 1'b0;
    obs = {oi0, ot0, rdy0, busy0};
    nCompared++;
    if (obs !== 4'b0101) begin
      nMismatched++;
      $display("[TB] FAIL single_turn got %b want %b", obs, 4'b0101);
    end
    step();
    obs = {oi0, ot0, rdy0, busy0};
    nCompared++;
    if (obs !== 4'b0110) begin
      nMismatched++;
      $display("[TB] FAIL single_idle got %b want %b", obs, 4'b0110);
    end
  endtask

  // 0x0F then 0xF0 with the second handshake on the final cycle of the first word.
  task automatic test_back_to_back();
    logic [7:0] wd;
    logic [3:0] obs, expv;
    din0 = 8'h0F; val0 = 1'b1;
    step();
    val0 = 1'b0;
    for (int w = 0; w < 2; w++) begin
      wd = (w == 0) ? 8'h0F : 8'hF0;
      for (int i = 0; i < NB; i++) begin
        expv = {(i < 8) ? wd[7 - i] : 1'b1, 1'b0, (i == NB - 1), 1'b1};
        obs  = {oi0, ot0, rdy0, busy0};
        nCompared++;
        if (obs !== expv) begin
          nMismatched++;
          $display("[TB] FAIL b2b_w%0d_bit%0d got %b want %b", w, i, obs, expv);
        end
        if (w == 0 && i == NB - 1) begin
          din0 = 8'hF0; val0 = 1'b1;
        end else begin
          val0 = 1'b0;
        end
        step();
      end
    end
    obs = {oi0, ot0, rdy0, busy0};
    nCompared++;
    if (obs !== 4'b0101) begin
      nMismatched++;
      $display("[TB] FAIL b2b_turn got %b want %b", obs, 4'b0101);
    end
    step();
    obs = {oi0, ot0, rdy0, busy0};
    nCompared++;
    if (obs !== 4'b0110) begin
      nMismatched++;
      $display("[TB] FAIL b2b_idle got %b want %b", obs, 4'b0110);
    end
  endtask

  // TURN=0 instance, 0x80 (parity 0): back to high-Z and not busy right after the word.
  task automatic test_turn0();
    logic [7:0] wd;
    logic [3:0] obs, expv;
    wd = 8'h80;
    din1 = wd; val1 = 1'b1;
    step();
    val1 = 1'b0;
    for (int i = 0; i < NB; i++) begin
      expv = {(i < 8) ? wd[7 - i] : 1'b0, 1'b0, (i == NB - 1), 1'b1};
      obs  = {oi1, ot1, rdy1, busy1};
      nCompared++;
      if (obs !== expv) begin
        nMismatched++;
        $display("[TB] FAIL turn0_bit%0d got %b want %b", i, obs, expv);
      end
      step();
    end
    obs = {oi1, ot1, rdy1, busy1};
    nCompared++;
    if (obs !== 4'b0110) begin
      nMismatched++;
      $display("[TB] FAIL turn0_end got %b want %b", obs, 4'b0110);
    end
  endtask

  // Reset on the 4th bit of 0xFF aborts the word immediately.
  task automatic test_reset_abort();
    logic [3:0] obs;
    din0 = 8'hFF; val0 = 1'b1;
    step();
    val0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obs = {oi0, ot0, rdy0, busy0};
      nCompared++;
      if (obs !== 4'b1001) begin
        nMismatched++;
        $display("[TB] FAIL abort_bit%0d got %b want %b", i, obs, 4'b1001);
      end
      if (i < 3) step();
    end
    rst0 = 1'b1;
    step();
    obs = {oi0, ot0, rdy0, busy0};
    nCompared++;
    if (obs !== 4'b0100) begin
      nMismatched++;
      $display("[TB] FAIL abort_rst got %b want %b", obs, 4'b0100);
    end
    rst0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      obs = {oi0, ot0, rdy0, busy0};
      nCompared++;
      if (obs !== 4'b0110) begin
        nMismatched++;
        $display("[TB] FAIL abort_after%0d got %b want %b", i, obs, 4'b0110);
      end
    end
  endtask

  // Random DIN_VALID/DIN against an independent cycle model of the TURN=1 instance.
  task automatic test_random_valid();
    int         phase;
    int         idx;
    int         tcnt;
    logic [7:0] word;
    logic [3:0] obs, expv;
    logic       expRdy, hs, b;
    phase = 0; idx = 0; tcnt = 0; word = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      case (phase)
        1: begin
          b = (idx < 8) ? word[7 - idx] : ~(^word);
          expRdy = (idx == NB - 1);
          expv = {b, 1'b0, expRdy, 1'b1};
        end
        2: begin
          expRdy = 1'b0;
          expv = 4'b0101;
        end
        default: begin
          expRdy = 1'b1;
          expv = 4'b0110;
        end
      endcase
      obs = {oi0, ot0, rdy0, busy0};
      nCompared++;
      if (obs !== expv) begin
        nMismatched++;
        $display("[TB] FAIL random_c%0d got %b want %b", c, obs, expv);
      end
      val0 = ($urandom_range(0, 3) == 0);
      din0 = 8'($urandom);
      hs = expRdy && val0;
      case (phase)
        1: begin
          if (idx == NB - 1) begin
            if (hs) begin
              word = din0; idx = 0;
            end else begin
              phase = 2; tcnt = 1;
            end
          end else begin
            idx++;
          end
        end
        2: begin
          tcnt--;
          if (tcnt == 0) phase = 0;
        end
        default: begin
          if (hs) begin
            word = din0; idx = 0; phase = 1;
          end
        end
      endcase
      step();
    end
    val0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_turn0();
    test_reset_abort();
    test_random_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
